fp32_dot_seq: RTL and testbench

Initiator-side sequencer for the `fp32_mac` A*B+C stream unit. It accepts a dot-product command (element count plus initial accumulator) and pulls element pairs from an operand stream. For each pair it issues one MAC operation with the running accumulator fed back as C, and returns the final FP32 sum on a result stream. It sits between the execute-stage operand buffers and the `fp32_mac` instance, which the parent instantiates.

---
 rtl/fp32_pkg.sv | 18 +
 rtl/fp32_dot_seq.sv | 120 ++++++++++++
 tb/tb_fp32_dot_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the dot-product sequencer.
//   dot_state_e : sequencer FSM states
//   FP32_ZERO   : +0.0 bit pattern
//   FP32_ONE    : +1.0 bit pattern
package fp32_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } dot_state_e;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp32_dot_seq.sv
// fp32_dot_seq: dot-product sequencer driving an external A*B+C MAC unit.
// A command (cmd_len pairs, cmd_init accumulator) pulls element pairs one
// at a time. Each pair is issued with the running accumulator as C. The
// final accumulator is then returned on the out stream.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/ready, cmd_len/init command stream
//   elem_valid/ready, elem_a/b    operand-pair stream
//   mac_in_valid/ready, mac_a/b/c MAC issue stream
//   mac_result_valid/ready/data   MAC result stream
//   out_valid/ready, out_data     final sum stream
//   busy                          high whenever not IDLE
module fp32_dot_seq
    import fp32_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_init,
    input  logic             elem_valid,
    output logic             elem_ready,
    input  logic [31:0]      elem_a,
    input  logic [31:0]      elem_b,
    output logic             mac_in_valid,
    input  logic             mac_in_ready,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic [31:0]      mac_c,
    input  logic             mac_result_valid,
    output logic             mac_result_ready,
    input  logic [31:0]      mac_result_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy
);

    dot_state_e       state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] rem_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= FP32_ZERO;
            opa_q   <= FP32_ZERO;
            opb_q   <= FP32_ZERO;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
        end
    end

    // rem is only decremented in WAIT, where it is known to be non-zero.
    // The check against zero happens before any further decrement, so it never wraps.
    assign rem_dec = rem_q - LEN_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    acc_d   = cmd_init;
                    rem_d   = cmd_len;
                    state_d = (cmd_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (elem_valid) begin
                    opa_d   = elem_a;
                    opb_d   = elem_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mac_in_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mac_result_valid) begin
                    acc_d   = mac_result_data;
                    rem_d   = rem_dec;
                    state_d = (rem_dec == '0) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend only on registered state. There is no input-to-output path.
    assign cmd_ready        = (state_q == IDLE);
    assign elem_ready       = (state_q == FETCH);
    assign mac_in_valid     = (state_q == ISSUE);
    assign mac_result_ready = (state_q == WAIT);
    assign out_valid        = (state_q == DONE);
    assign busy             = (state_q != IDLE);

    assign mac_a    = opa_q;
    assign mac_b    = opb_q;
    assign mac_c    = acc_q;
    assign out_data = acc_q;

endmodule

// File: tb/tb_fp32_dot_seq.sv
// Directed self-checking bench for fp32_dot_seq. The bench plays the MAC
// unit itself, with a 2-cycle response. Its results come from a table of
// hand-computed FP32 A*B+C values.
module tb_fp32_dot_seq;
    import fp32_pkg::*;

    localparam int LEN_W = 8;
    localparam int TMO   = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [31:0]      cmd_init;
    logic             elem_valid;
    logic             elem_ready;
    logic [31:0]      elem_a, elem_b;
    logic             mac_in_valid;
    logic             mac_in_ready;
    logic [31:0]      mac_a, mac_b, mac_c;
    logic             mac_result_valid;
    logic             mac_result_ready;
    logic [31:0]      mac_result_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int mac_hs   = 0;
    int mac_vld  = 0;

    fp32_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_init(cmd_init),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_a(elem_a), .elem_b(elem_b),
        .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_result_valid(mac_result_valid), .mac_result_ready(mac_result_ready),
        .mac_result_data(mac_result_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mac_in_valid) mac_vld++;
        if (mac_in_valid && mac_in_ready) mac_hs++;
    end

    // Hand-computed A*B+C for the operand triples used below.
    function automatic logic [31:0] mac_model(input logic [31:0] a, b, c);
        logic [95:0] k;
        k = {a, b, c};
        case (k)
            {32'h3F800000, 32'h40000000, 32'h00000000}: return 32'h40000000; // 1*2+0 = 2
            {32'h40000000, 32'h40400000, 32'h40000000}: return 32'h41000000; // 2*3+2 = 8
            {32'h40000000, 32'h40000000, 32'h3F800000}: return 32'h40A00000; // 2*2+1 = 5
            {32'h3F800000, 32'h3F800000, 32'h00000000}: return 32'h3F800000; // 1*1+0 = 1
            {32'h3F800000, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1*1+1 = 2
            {32'h3F800000, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1*1+2 = 3
            {32'h3F800000, 32'h3F800000, 32'h40400000}: return 32'h40800000; // 1*1+3 = 4
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [31:0] init);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = len; cmd_init = init;
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic feed_elem(input logic [31:0] a, b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            chk("fetch_wait", {30'b0, elem_ready, busy}, 32'd3);
        end
        @(negedge clk);
        elem_valid = 1'b1; elem_a = a; elem_b = b;
        n = 0;
        while (!elem_ready && n < TMO) begin @(negedge clk); n++; end
        chk("elem_timeout", {31'b0, n < TMO}, 32'd1);
        @(posedge clk);
        #1 elem_valid = 1'b0;
    endtask

    task automatic serve_mac(input logic [31:0] exp_c, input int stall);
        int n;
        logic [31:0] a, b, c;
        @(negedge clk);
        n = 0;
        while (!mac_in_valid && n < TMO) begin @(negedge clk); n++; end
        chk("issue_timeout", {31'b0, n < TMO}, 32'd1);
        a = mac_a; b = mac_b; c = mac_c;
        chk("issue_mac_c", c, exp_c);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_ops", {31'b0, {mac_a, mac_b, mac_c} === {a, b, c}}, 32'd1);
            chk("stall_elem_ready", {31'b0, elem_ready}, 32'd0);
        end
        mac_in_ready = 1'b1;
        @(posedge clk);
        #1 mac_in_ready = 1'b0;
        // Result comes back on the second cycle after issue.
        @(negedge clk);
        @(negedge clk);
        mac_result_valid = 1'b1; mac_result_data = mac_model(a, b, c);
        n = 0;
        while (!mac_result_ready && n < TMO) begin @(negedge clk); n++; end
        chk("result_timeout", {31'b0, n < TMO}, 32'd1);
        @(posedge clk);
        #1 mac_result_valid = 1'b0;
    endtask

    task automatic get_out(input logic [31:0] exp, input int hold);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < TMO) begin @(negedge clk); n++; end
        chk("out_timeout", {31'b0, n < TMO}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_out_data", out_data, exp);
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        chk("out_data", out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_out", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hs"}, {26'b0, cmd_ready, elem_ready, mac_in_valid,
                           mac_result_ready, out_valid, busy}, 32'b100000);
        chk({tag, "_mac_a"}, mac_a, FP32_ZERO);
        chk({tag, "_mac_b"}, mac_b, FP32_ZERO);
        chk({tag, "_mac_c"}, mac_c, FP32_ZERO);
        chk({tag, "_out_data"}, out_data, FP32_ZERO);
    endtask

    initial begin
        int h0, v0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_len = '0; cmd_init = '0;
        elem_valid = 1'b0; elem_a = '0; elem_b = '0;
        mac_in_ready = 1'b0; mac_result_valid = 1'b0; mac_result_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Basic: 1*2 + 2*3 = 8.0, with 10 cycles of out back-pressure.
        h0 = mac_hs;
        send_cmd(8'd2, FP32_ZERO);
        @(negedge clk);
        chk("cmd_to_fetch", {30'b0, elem_ready, busy}, 32'd3);
        feed_elem(FP32_ONE, 32'h40000000, 0);
        serve_mac(FP32_ZERO, 0);
        feed_elem(32'h40000000, 32'h40400000, 0);
        serve_mac(32'h40000000, 0);
        get_out(32'h41000000, 10);
        chk("basic_mac_hs", mac_hs - h0, 32'd2);

        // Zero length: result the cycle after accept, no MAC traffic.
        v0 = mac_vld;
        send_cmd(8'd0, 32'h40400000);
        @(negedge clk);
        chk("zero_out_valid", {31'b0, out_valid}, 32'd1);
        chk("zero_out_data", out_data, 32'h40400000);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("zero_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("zero_mac_vld", mac_vld - v0, 32'd0);

        // MAC input stall: 5 cycles with mac_in_ready low on the first element.
        send_cmd(8'd2, FP32_ZERO);
        feed_elem(FP32_ONE, 32'h40000000, 0);
        serve_mac(FP32_ZERO, 5);
        feed_elem(32'h40000000, 32'h40400000, 0);
        serve_mac(32'h40000000, 0);
        get_out(32'h41000000, 0);

        // Reset while in WAIT.
        send_cmd(8'd1, FP32_ONE);
        feed_elem(32'h40000000, 32'h40000000, 0);
        @(negedge clk);
        chk("pre_rst_issue", {31'b0, mac_in_valid}, 32'd1);
        mac_in_ready = 1'b1;
        @(posedge clk);
        #1 mac_in_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait", {31'b0, mac_result_ready}, 32'd1);
        rst = 1'b1;
        #1 chk_reset_outputs("rst_in_wait");
        @(negedge clk);
        rst = 1'b0;
        send_cmd(8'd1, FP32_ONE);
        feed_elem(32'h40000000, 32'h40000000, 0);
        serve_mac(FP32_ONE, 0);
        get_out(32'h40A00000, 0);

        // len=4 of 1*1, first gap-free then with 3-cycle element gaps: both 4.0.
        send_cmd(8'd4, FP32_ZERO);
        for (int i = 0; i < 4; i++) begin
            feed_elem(FP32_ONE, FP32_ONE, 0);
            serve_mac(mac_model(FP32_ONE, FP32_ONE, 32'hDEADBEEF) == 32'hDEADBEEF ?
                      (i == 0 ? 32'h00000000 : i == 1 ? 32'h3F800000 :
                       i == 2 ? 32'h40000000 : 32'h40400000) : 32'h0, 0);
        end
        get_out(32'h40800000, 0);

        send_cmd(8'd4, FP32_ZERO);
        for (int i = 0; i < 4; i++) begin
            feed_elem(FP32_ONE, FP32_ONE, 3);
            serve_mac(i == 0 ? 32'h00000000 : i == 1 ? 32'h3F800000 :
                      i == 2 ? 32'h40000000 : 32'h40400000, 0);
        end
        get_out(32'h40800000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
